axi_lite_sram_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the single-ported AXI-lite SRAM model between the IFU (read-only) and the LSU (read and write).
- Sits between the core's fetch/memory stages and the SRAM slave.
- Locks one transaction at a time: grant is held from address handshake through response handshake.
- Round-robin between IFU and LSU, so instruction fetch and data access cannot starve each other.

---
 rtl/axi_lite_sram_arbiter_pkg.sv | 27 ++
 rtl/axi_lite_sram_arbiter_rr_arbiter2.sv | 46 ++++
 rtl/axi_lite_sram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi_lite_sram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_sram_arbiter_pkg
// Description : Shared constants for the IFU/LSU AXI-lite SRAM arbiter:
//               FSM state encoding and master identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_sram_arbiter_pkg;

  typedef logic [2:0] state_t;

  // One state per phase of the granted transaction; IDLE is the only
  // state in which arbitration happens.
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_IFU_AR = 3'd1;
  localparam state_t ST_IFU_R  = 3'd2;
  localparam state_t ST_LSU_AR = 3'd3;
  localparam state_t ST_LSU_R  = 3'd4;
  localparam state_t ST_LSU_W  = 3'd5;
  localparam state_t ST_LSU_B  = 3'd6;

  // Master identifiers used by the round-robin pointer.
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage : axi_lite_sram_arbiter_pkg
`default_nettype wire

// File: rtl/axi_lite_sram_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin picker. On a tie the master that did
//               not win last time is chosen. The pointer only advances when
//               the caller accepts the grant (en).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import axi_lite_sram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic en,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_grant_q;
  logic last_grant_d;

  // Pick a winner; on a tie favour the master that lost the previous round.
  always_comb begin
    gnt_valid    = req_ifu | req_lsu;
    gnt_id       = MST_IFU;
    if (req_ifu && req_lsu) begin
      gnt_id = ~last_grant_q;
    end else if (req_lsu) begin
      gnt_id = MST_LSU;
    end
    last_grant_d = (en && gnt_valid) ? gnt_id : last_grant_q;
  end

  // Pointer register; resets to IFU so the LSU wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= MST_IFU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/axi_lite_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_sram_arbiter
// Description : Shares one AXI-lite SRAM slave between the IFU (read only)
//               and the LSU (read/write). One transaction is locked from
//               address handshake to response handshake; IDLE re-arbitrates
//               round-robin between the two masters.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_sram_arbiter
  import axi_lite_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  // IFU read channel
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  // LSU read channel
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  // LSU write channel
  input  logic [ADDR_W-1:0] lsu_waddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_w_shifter,
  input  logic [7:0]        lsu_w_DWHB,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic              lsu_bvalid,
  input  logic              lsu_bready,
  // Slave side
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [ADDR_W-1:0] s_waddr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [7:0]        s_w_shifter,
  output logic [7:0]        s_w_DWHB,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic              s_bvalid,
  output logic              s_bready
);

  state_t state_q;
  state_t state_d;
  logic   gnt_valid;
  logic   gnt_id;
  logic   arb_en;

  assign arb_en = (state_q == ST_IDLE);

  rr_arbiter2 u_rr_arbiter2 (
    .clk       (clk),
    .rstn      (rstn),
    .req_ifu   (ifu_arvalid),
    .req_lsu   (lsu_arvalid | lsu_wvalid),
    .en        (arb_en),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant in IDLE, then advance on each slave handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          if (gnt_id == MST_IFU) begin
            state_d = ST_IFU_AR;
          end else if (lsu_wvalid) begin
            state_d = ST_LSU_W;
          end else begin
            state_d = ST_LSU_AR;
          end
        end
      end
      ST_IFU_AR: if (ifu_arvalid && s_arready) state_d = ST_IFU_R;
      ST_IFU_R:  if (s_rvalid && ifu_rready)   state_d = ST_IDLE;
      ST_LSU_AR: if (lsu_arvalid && s_arready) state_d = ST_LSU_R;
      ST_LSU_R:  if (s_rvalid && lsu_rready)   state_d = ST_IDLE;
      ST_LSU_W:  if (lsu_wvalid && s_wready)   state_d = ST_LSU_B;
      ST_LSU_B:  if (s_bvalid && lsu_bready)   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output muxing decoded purely from state; everything not forwarded is 0.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rvalid  = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_waddr     = '0;
    s_wdata     = '0;
    s_w_shifter = '0;
    s_w_DWHB    = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    case (state_q)
      ST_IFU_AR: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid;
        ifu_arready = s_arready;
      end
      ST_IFU_R: begin
        ifu_rvalid = s_rvalid;
        ifu_rdata  = s_rdata;
        s_rready   = ifu_rready;
      end
      ST_LSU_AR: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid;
        lsu_arready = s_arready;
      end
      ST_LSU_R: begin
        lsu_rvalid = s_rvalid;
        lsu_rdata  = s_rdata;
        s_rready   = lsu_rready;
      end
      ST_LSU_W: begin
        s_waddr     = lsu_waddr;
        s_wdata     = lsu_wdata;
        s_w_shifter = lsu_w_shifter;
        s_w_DWHB    = lsu_w_DWHB;
        s_wvalid    = lsu_wvalid;
        lsu_wready  = s_wready;
      end
      ST_LSU_B: begin
        lsu_bvalid = s_bvalid;
        s_bready   = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule : axi_lite_sram_arbiter
`default_nettype wire

// File: tb/tb_axi_lite_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_sram_arbiter
// Description : Self-checking bench for axi_lite_sram_arbiter. A transaction
//               level model (owner / kind / phase) predicts every output on
//               each falling edge; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sram_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rstn;
  logic [ADDR_W-1:0] ifu_araddr;
  logic              ifu_arvalid;
  logic              ifu_arready;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic              ifu_rready;
  logic [ADDR_W-1:0] lsu_araddr;
  logic              lsu_arvalid;
  logic              lsu_arready;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_rvalid;
  logic              lsu_rready;
  logic [ADDR_W-1:0] lsu_waddr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_w_shifter;
  logic [7:0]        lsu_w_DWHB;
  logic              lsu_wvalid;
  logic              lsu_wready;
  logic              lsu_bvalid;
  logic              lsu_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic              s_rvalid;
  logic              s_rready;
  logic [ADDR_W-1:0] s_waddr;
  logic [DATA_W-1:0] s_wdata;
  logic [7:0]        s_w_shifter;
  logic [7:0]        s_w_DWHB;
  logic              s_wvalid;
  logic              s_wready;
  logic              s_bvalid;
  logic              s_bready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_lite_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata), .lsu_w_shifter(lsu_w_shifter),
    .lsu_w_DWHB(lsu_w_DWHB), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_waddr(s_waddr), .s_wdata(s_wdata), .s_w_shifter(s_w_shifter),
    .s_w_DWHB(s_w_DWHB), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_busy: a transaction holds the slave; m_owner: 0=IFU 1=LSU;
  // m_write: the held transaction is an LSU write; m_resp: response phase.
  logic m_busy, m_owner, m_write, m_resp, m_last;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_owner <= 1'b0; m_write <= 1'b0; m_resp <= 1'b0; m_last <= 1'b0;
    end else if (!m_busy) begin
      if (ifu_arvalid || lsu_arvalid || lsu_wvalid) begin
        logic win;
        if (ifu_arvalid && (lsu_arvalid || lsu_wvalid)) win = !m_last;
        else win = !ifu_arvalid;
        m_busy  <= 1'b1;
        m_owner <= win;
        m_write <= win && lsu_wvalid;
        m_resp  <= 1'b0;
        m_last  <= win;
      end
    end else if (!m_resp) begin
      if (m_write ? (lsu_wvalid && s_wready)
                  : ((m_owner ? lsu_arvalid : ifu_arvalid) && s_arready))
        m_resp <= 1'b1;
    end else begin
      if (m_write ? (s_bvalid && lsu_bready)
                  : (s_rvalid && (m_owner ? lsu_rready : ifu_rready)))
        m_busy <= 1'b0;
    end
  end

  // Observed grant order (recorded from DUT address-phase readiness).
  logic rec_en = 1'b0;
  int   dut_grants[$];

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    logic ai, al, ri, rl, w, b;
    ai = m_busy && !m_owner && !m_write && !m_resp;
    al = m_busy &&  m_owner && !m_write && !m_resp;
    ri = m_busy && !m_owner && !m_write &&  m_resp;
    rl = m_busy &&  m_owner && !m_write &&  m_resp;
    w  = m_busy && m_write && !m_resp;
    b  = m_busy && m_write &&  m_resp;
    chk("ifu_arready", ifu_arready, ai & s_arready);
    chk("lsu_arready", lsu_arready, al & s_arready);
    chk("s_arvalid",   s_arvalid,   (ai & ifu_arvalid) | (al & lsu_arvalid));
    chk("s_araddr",    s_araddr,    ai ? ifu_araddr : (al ? lsu_araddr : 64'h0));
    chk("ifu_rvalid",  ifu_rvalid,  ri & s_rvalid);
    chk("ifu_rdata",   ifu_rdata,   ri ? s_rdata : 64'h0);
    chk("lsu_rvalid",  lsu_rvalid,  rl & s_rvalid);
    chk("lsu_rdata",   lsu_rdata,   rl ? s_rdata : 64'h0);
    chk("s_rready",    s_rready,    (ri & ifu_rready) | (rl & lsu_rready));
    chk("s_wvalid",    s_wvalid,    w & lsu_wvalid);
    chk("s_waddr",     s_waddr,     w ? lsu_waddr : 64'h0);
    chk("s_wdata",     s_wdata,     w ? lsu_wdata : 64'h0);
    chk("s_w_shifter", s_w_shifter, w ? lsu_w_shifter : 8'h0);
    chk("s_w_DWHB",    s_w_DWHB,    w ? lsu_w_DWHB : 8'h0);
    chk("lsu_wready",  lsu_wready,  w & s_wready);
    chk("lsu_bvalid",  lsu_bvalid,  b & s_bvalid);
    chk("s_bready",    s_bready,    b & lsu_bready);
    if (rec_en && ifu_arready) dut_grants.push_back(0);
    if (rec_en && lsu_arready) dut_grants.push_back(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_waddr = '0; lsu_wdata = '0; lsu_w_shifter = '0; lsu_w_DWHB = '0;
    lsu_wvalid = 0; lsu_bready = 0;
    s_arready = 0; s_rdata = '0; s_rvalid = 0; s_wready = 0; s_bvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rstn = 1'b0;
    step(); step();
    neg();
    chk("reset_s_arvalid", s_arvalid, 0);
    chk("reset_ifu_rdata", ifu_rdata, 0);
    step(); rstn = 1'b1;

    // ---- IFU alone ----
    ifu_araddr = 64'h8000_0000; ifu_arvalid = 1; s_arready = 1;
    neg();
    chk("ifu_idle_no_fwd", s_arvalid, 0);
    step();
    neg();
    chk("ifu_s_arvalid_1cyc", s_arvalid, 1);
    chk("ifu_s_araddr", s_araddr, 64'h8000_0000);
    step();
    ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 64'h1234; ifu_rready = 1;
    neg();
    chk("ifu_rdata", ifu_rdata, 64'h1234);
    chk("ifu_lsu_rvalid", lsu_rvalid, 0);
    step();
    clear_inputs();
    neg();
    chk("ifu_back_idle", ifu_rvalid, 0);

    // ---- reset pulse, then IFU read vs LSU write tie ----
    #2 rstn = 1'b0;
    step(); rstn = 1'b1;
    ifu_araddr = 64'h8000_0000; ifu_arvalid = 1;
    lsu_waddr = 64'h8000_0100; lsu_wdata = 64'hDEAD_BEEF; lsu_wvalid = 1;
    lsu_w_shifter = 8'h03; lsu_w_DWHB = 8'h04;
    s_arready = 1; s_wready = 1;
    step();
    neg();
    chk("tie_lsu_first_wvalid", s_wvalid, 1);
    chk("tie_s_waddr", s_waddr, 64'h8000_0100);
    chk("tie_ifu_arready", ifu_arready, 0);
    step();
    lsu_wvalid = 0; s_bvalid = 1; lsu_bready = 1;
    neg();
    chk("tie_lsu_bvalid", lsu_bvalid, 1);
    step();
    s_bvalid = 0; lsu_bready = 0;
    neg();
    chk("tie_idle_gap", s_arvalid, 0);
    step();
    neg();
    chk("tie_ifu_after", s_arvalid, 1);
    step();
    ifu_arvalid = 0; s_rvalid = 1; s_rdata = 64'h55; ifu_rready = 1;
    step();
    clear_inputs();

    // ---- sustained contention, 4 rounds ----
    ifu_araddr = 64'h8000_1000; lsu_araddr = 64'h8000_2000;
    ifu_arvalid = 1; lsu_arvalid = 1; s_arready = 1; s_rvalid = 1;
    s_rdata = 64'hCAFE; ifu_rready = 1; lsu_rready = 1;
    dut_grants.delete();
    rec_en = 1'b1;
    for (int i = 0; i < 12; i++) step();
    clear_inputs();
    neg();
    rec_en = 1'b0;
    chk("rr_count", dut_grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (i < dut_grants.size()) ? dut_grants[i] : -1;
      chk($sformatf("rr_grant%0d", i), g, (i % 2 == 0) ? 1 : 0);
    end

    // ---- backpressure on IFU read, LSU waits ----
    step();
    ifu_araddr = 64'h8000_3000; ifu_arvalid = 1; s_arready = 1;
    step(); step();
    ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 64'hABCD;
    lsu_araddr = 64'h8000_0200; lsu_arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("bp_ifu_rvalid", ifu_rvalid, 1);
      chk("bp_lsu_waits", lsu_arready | s_arvalid, 0);
      step();
    end
    ifu_rready = 1; s_arready = 1;
    neg();
    chk("bp_complete_rready", s_rready, 1);
    step();
    ifu_rready = 0;
    neg();
    chk("bp_idle_after", ifu_rvalid, 0);
    step();
    neg();
    chk("bp_lsu_araddr", s_araddr, 64'h8000_0200);
    step();
    lsu_arvalid = 0; s_arready = 0; s_rdata = 64'h77; lsu_rready = 0;
    neg();
    chk("lsu_rdata", lsu_rdata, 64'h77);
    chk("lsu_r_ifu_rvalid", ifu_rvalid, 0);

    // ---- reset mid LSU_R ----
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_lsu_rvalid", lsu_rvalid, 0);
    chk("rst_mid_lsu_rdata", lsu_rdata, 0);
    chk("rst_mid_s_rready", s_rready, 0);
    clear_inputs();
    step(); rstn = 1'b1;
    neg();
    chk("rst_release_idle", lsu_rvalid | s_arvalid | s_wvalid, 0);

    // ---- LSU read and write together: write first ----
    step();
    lsu_araddr = 64'h8000_0300; lsu_arvalid = 1;
    lsu_waddr = 64'h8000_0308; lsu_wdata = 64'h1122_3344; lsu_wvalid = 1;
    lsu_w_shifter = 8'h03; lsu_w_DWHB = 8'h04;
    s_arready = 1; s_wready = 1;
    step();
    neg();
    chk("lrw_write_first", s_wvalid, 1);
    chk("lrw_no_ar", s_arvalid, 0);
    chk("lrw_shifter", s_w_shifter, 8'h03);
    chk("lrw_dwhb", s_w_DWHB, 8'h04);
    step();
    lsu_wvalid = 0; s_bvalid = 1; lsu_bready = 1;
    step();
    s_bvalid = 0; lsu_bready = 0;
    neg();
    chk("lrw_idle_gap", s_arvalid, 0);
    step();
    neg();
    chk("lrw_read_after", s_araddr, 64'h8000_0300);
    step();
    lsu_arvalid = 0; s_rvalid = 1; s_rdata = 64'h99; lsu_rready = 1;
    step();
    clear_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axi_lite_sram_arbiter
`default_nettype wire
